axi_burst_slave: RTL and testbench

AXI_BURST_SLAVE -- requirements
Module: axi_burst_slave

---
 rtl/axi_burst_pkg.sv | 26 ++
 rtl/axi_burst_addr.sv | 47 ++++
 rtl/axi_burst_slave.sv | 213 +++++++++++++++++++++
 tb/tb_axi_burst_slave.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_burst_pkg.sv
// Shared FSM state, response and burst-type definitions for the AXI burst slave.
package axi_burst_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_DATA,
        WR_ACC,
        WR_RESP,
        RD_ACC,
        RD_DATA
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_INCR  = 2'd1;
    localparam logic [1:0] BURST_WRAP  = 2'd2;

    // Only full-width FIXED/INCR bursts reach the system bus; WRAP and the reserved code do not.
    function automatic logic burst_is_err(input logic [1:0] burst, input logic [2:0] size,
                                          input logic [2:0] native_size);
        return !((burst == BURST_FIXED) || (burst == BURST_INCR)) || (size != native_size);
    endfunction

endpackage

// File: rtl/axi_burst_addr.sv
// Tracks the current beat address and beat count of the burst in flight.
module axi_burst_addr
    import axi_burst_pkg::*;
#(
    parameter int AXI_DW = 32,
    parameter int AXI_AW = 32,
    parameter int AXI_LW = 4
) (
    input  logic              axi_clk_i,
    input  logic              axi_rst_i,
    input  logic              load,
    input  logic [AXI_AW-1:0] load_addr,
    input  logic [AXI_LW-1:0] load_len,
    input  logic [1:0]        load_burst,
    input  logic              step,
    output logic [AXI_AW-1:0] beat_addr,
    output logic              last_beat
);

    localparam logic [AXI_AW-1:0] BEAT_BYTES = AXI_AW'(AXI_DW / 8);

    logic [AXI_LW-1:0] len_q;
    logic [AXI_LW-1:0] cnt_q;
    logic [1:0]        burst_q;

    always_ff @(posedge axi_clk_i) begin
        if (axi_rst_i) begin
            beat_addr <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            burst_q   <= BURST_FIXED;
        end else if (load) begin
            beat_addr <= load_addr;
            len_q     <= load_len;
            cnt_q     <= '0;
            burst_q   <= load_burst;
        end else if (step) begin
            cnt_q <= cnt_q + AXI_LW'(1);
            if (burst_q == BURST_INCR) begin
                beat_addr <= beat_addr + BEAT_BYTES;
            end
        end
    end

    assign last_beat = (cnt_q == len_q);

endmodule

// File: rtl/axi_burst_slave.sv
// AXI3/AXI4 burst slave: serves one transaction at a time over an ack-based system bus.
// Optional sys-bus timeout is built when AXI_BURST_SLAVE_TIMEOUT_EN is defined.
module axi_burst_slave
    import axi_burst_pkg::*;
#(
    parameter int AXI_DW  = 32,
    parameter int AXI_AW  = 32,
    parameter int AXI_IW  = 12,
    parameter int AXI_LW  = 4,
    parameter int ARB_RR  = 0,
    parameter int TIMEOUT = 32
) (
    input  logic                axi_clk_i,
    input  logic                axi_rst_i,
    input  logic [AXI_IW-1:0]   axi_awid_i,
    input  logic [AXI_AW-1:0]   axi_awaddr_i,
    input  logic [AXI_LW-1:0]   axi_awlen_i,
    input  logic [2:0]          axi_awsize_i,
    input  logic [1:0]          axi_awburst_i,
    input  logic                axi_awvalid_i,
    output logic                axi_awready_o,
    input  logic [AXI_DW-1:0]   axi_wdata_i,
    input  logic [AXI_DW/8-1:0] axi_wstrb_i,
    input  logic                axi_wlast_i,
    input  logic                axi_wvalid_i,
    output logic                axi_wready_o,
    output logic [AXI_IW-1:0]   axi_bid_o,
    output logic [1:0]          axi_bresp_o,
    output logic                axi_bvalid_o,
    input  logic                axi_bready_i,
    input  logic [AXI_IW-1:0]   axi_arid_i,
    input  logic [AXI_AW-1:0]   axi_araddr_i,
    input  logic [AXI_LW-1:0]   axi_arlen_i,
    input  logic [2:0]          axi_arsize_i,
    input  logic [1:0]          axi_arburst_i,
    input  logic                axi_arvalid_i,
    output logic                axi_arready_o,
    output logic [AXI_IW-1:0]   axi_rid_o,
    output logic [AXI_DW-1:0]   axi_rdata_o,
    output logic [1:0]          axi_rresp_o,
    output logic                axi_rlast_o,
    output logic                axi_rvalid_o,
    input  logic                axi_rready_i,
    output logic [AXI_AW-1:0]   sys_addr_o,
    output logic [AXI_DW-1:0]   sys_wdata_o,
    output logic [AXI_DW/8-1:0] sys_sel_o,
    output logic                sys_wen_o,
    output logic                sys_ren_o,
    input  logic [AXI_DW-1:0]   sys_rdata_i,
    input  logic                sys_err_i,
    input  logic                sys_ack_i
);

    localparam logic [2:0] NATIVE_SIZE = 3'($clog2(AXI_DW / 8));

    state_t              state;
    state_t              state_nxt;
    logic                rr_rd_q;
    logic                rd_pri;
    logic                grant_wr;
    logic                grant_rd;
    logic [AXI_IW-1:0]   id_q;
    logic                err_burst_q;
    logic                werr_q;
    logic                wlast_q;
    logic                acc_prev_q;
    logic [AXI_DW-1:0]   wdata_q;
    logic [AXI_DW/8-1:0] wstrb_q;
    logic [AXI_DW-1:0]   rdata_q;
    logic [1:0]          rresp_q;
    logic                in_acc;
    logic                acc_first;
    logic                acc_done;
    logic                acc_err;
    logic                timeout_hit;
    logic                w_hs;
    logic                addr_step;
    logic                last_beat;
    logic [AXI_AW-1:0]   beat_addr;

    // Round-robin hands a contested cycle to read only after a write was the last grant.
    assign rd_pri    = (ARB_RR != 0) && rr_rd_q;
    assign grant_wr  = (state == IDLE) && axi_awvalid_i && !(axi_arvalid_i && rd_pri);
    assign grant_rd  = (state == IDLE) && axi_arvalid_i && !grant_wr;
    assign in_acc    = (state == WR_ACC) || (state == RD_ACC);
    assign acc_first = in_acc && !acc_prev_q;
    assign w_hs      = (state == WR_DATA) && axi_wvalid_i;
    assign acc_done  = in_acc && (err_burst_q || sys_ack_i || timeout_hit);
    assign acc_err   = err_burst_q || (sys_ack_i ? sys_err_i : timeout_hit);
    assign addr_step = ((state == WR_ACC) && acc_done && !wlast_q) ||
                       ((state == RD_DATA) && axi_rready_i && !last_beat);

`ifdef AXI_BURST_SLAVE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] to_cnt_q;

    always_ff @(posedge axi_clk_i) begin
        if (axi_rst_i || !in_acc || acc_done) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_q + TW'(1);
        end
    end

    assign timeout_hit = in_acc && !err_burst_q && (to_cnt_q == TW'(TIMEOUT - 1));
`else
    // No counter: an access waits for sys_ack_i forever (constant-false for any legal TIMEOUT).
    assign timeout_hit = (TIMEOUT < 0);
`endif

    axi_burst_addr #(
        .AXI_DW (AXI_DW),
        .AXI_AW (AXI_AW),
        .AXI_LW (AXI_LW)
    ) u_addr (
        .axi_clk_i  (axi_clk_i),
        .axi_rst_i  (axi_rst_i),
        .load       (grant_wr || grant_rd),
        .load_addr  (grant_wr ? axi_awaddr_i  : axi_araddr_i),
        .load_len   (grant_wr ? axi_awlen_i   : axi_arlen_i),
        .load_burst (grant_wr ? axi_awburst_i : axi_arburst_i),
        .step       (addr_step),
        .beat_addr  (beat_addr),
        .last_beat  (last_beat)
    );

    always_ff @(posedge axi_clk_i) begin
        if (axi_rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant_wr) begin
                    state_nxt = WR_DATA;
                end else if (grant_rd) begin
                    state_nxt = RD_ACC;
                end
            end
            WR_DATA: if (w_hs) state_nxt = WR_ACC;
            WR_ACC:  if (acc_done) state_nxt = wlast_q ? WR_RESP : WR_DATA;
            WR_RESP: if (axi_bready_i) state_nxt = IDLE;
            RD_ACC:  if (acc_done) state_nxt = RD_DATA;
            RD_DATA: if (axi_rready_i) state_nxt = last_beat ? IDLE : RD_ACC;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        axi_awready_o = grant_wr;
        axi_arready_o = grant_rd;
        axi_wready_o  = (state == WR_DATA);
        axi_bvalid_o  = (state == WR_RESP);
        axi_bresp_o   = ((state == WR_RESP) && werr_q) ? RESP_SLVERR : RESP_OKAY;
        axi_bid_o     = id_q;
        axi_rvalid_o  = (state == RD_DATA);
        axi_rlast_o   = (state == RD_DATA) && last_beat;
        axi_rresp_o   = rresp_q;
        axi_rdata_o   = rdata_q;
        axi_rid_o     = id_q;
        sys_wen_o     = (state == WR_ACC) && acc_first && !err_burst_q;
        sys_ren_o     = (state == RD_ACC) && acc_first && !err_burst_q;
        sys_addr_o    = beat_addr;
        sys_wdata_o   = wdata_q;
        sys_sel_o     = wstrb_q;
    end

    always_ff @(posedge axi_clk_i) begin
        if (axi_rst_i) begin
            rr_rd_q     <= 1'b0;
            err_burst_q <= 1'b0;
            werr_q      <= 1'b0;
            wlast_q     <= 1'b0;
            acc_prev_q  <= 1'b0;
            rdata_q     <= '0;
            rresp_q     <= RESP_OKAY;
        end else begin
            acc_prev_q <= in_acc;
            if (grant_wr || grant_rd) begin
                rr_rd_q     <= grant_wr;
                err_burst_q <= grant_wr ? burst_is_err(axi_awburst_i, axi_awsize_i, NATIVE_SIZE)
                                        : burst_is_err(axi_arburst_i, axi_arsize_i, NATIVE_SIZE);
                werr_q      <= 1'b0;
            end
            if (w_hs) begin
                wlast_q <= axi_wlast_i || last_beat;
            end
            if ((state == WR_ACC) && acc_done && acc_err) begin
                werr_q <= 1'b1;
            end
            if ((state == RD_ACC) && acc_done) begin
                rdata_q <= (sys_ack_i && !err_burst_q) ? sys_rdata_i : '0;
                rresp_q <= acc_err ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

    always_ff @(posedge axi_clk_i) begin
        if (grant_wr || grant_rd) begin
            id_q <= grant_wr ? axi_awid_i : axi_arid_i;
        end
        if (w_hs) begin
            wdata_q <= axi_wdata_i;
            wstrb_q <= axi_wstrb_i;
        end
    end

endmodule

// File: tb/tb_axi_burst_slave.sv
// Directed self-checking bench for axi_burst_slave (round-robin and write-priority instances).
module tb_axi_burst_slave;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int IW = 12;
    localparam int LW = 4;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [IW-1:0]   awid = '0, arid = '0;
    logic [AW-1:0]   awaddr = '0, araddr = '0;
    logic [LW-1:0]   awlen = '0, arlen = '0;
    logic [2:0]      awsize = '0, arsize = '0;
    logic [1:0]      awburst = '0, arburst = '0;
    logic            awvalid = 0, arvalid = 0, wvalid = 0, wlast = 0, bready = 0, rready = 0;
    logic [DW-1:0]   wdata = '0;
    logic [DW/8-1:0] wstrb = '0;
    logic [DW-1:0]   sys_rdata = '0;
    logic            sys_err = 0, sys_ack = 0, stray_ack = 0;

    logic            awready, arready, wready, bvalid, rvalid, rlast, s_wen, s_ren;
    logic [IW-1:0]   bid, rid;
    logic [1:0]      bresp, rresp;
    logic [DW-1:0]   rdata, s_wdata;
    logic [AW-1:0]   s_addr;
    logic [DW/8-1:0] s_sel;

    logic            awready_0, arready_0, wready_0, bvalid_0, rvalid_0, rlast_0, s_wen_0, s_ren_0;
    logic [IW-1:0]   bid_0, rid_0;
    logic [1:0]      bresp_0, rresp_0;
    logic [DW-1:0]   rdata_0, s_wdata_0;
    logic [AW-1:0]   s_addr_0;
    logic [DW/8-1:0] s_sel_0;

    axi_burst_slave #(.AXI_DW(DW), .AXI_AW(AW), .AXI_IW(IW), .AXI_LW(LW), .ARB_RR(1), .TIMEOUT(TO)) u_dut (
        .axi_clk_i(clk), .axi_rst_i(rst),
        .axi_awid_i(awid), .axi_awaddr_i(awaddr), .axi_awlen_i(awlen), .axi_awsize_i(awsize),
        .axi_awburst_i(awburst), .axi_awvalid_i(awvalid), .axi_awready_o(awready),
        .axi_wdata_i(wdata), .axi_wstrb_i(wstrb), .axi_wlast_i(wlast), .axi_wvalid_i(wvalid),
        .axi_wready_o(wready),
        .axi_bid_o(bid), .axi_bresp_o(bresp), .axi_bvalid_o(bvalid), .axi_bready_i(bready),
        .axi_arid_i(arid), .axi_araddr_i(araddr), .axi_arlen_i(arlen), .axi_arsize_i(arsize),
        .axi_arburst_i(arburst), .axi_arvalid_i(arvalid), .axi_arready_o(arready),
        .axi_rid_o(rid), .axi_rdata_o(rdata), .axi_rresp_o(rresp), .axi_rlast_o(rlast),
        .axi_rvalid_o(rvalid), .axi_rready_i(rready),
        .sys_addr_o(s_addr), .sys_wdata_o(s_wdata), .sys_sel_o(s_sel), .sys_wen_o(s_wen),
        .sys_ren_o(s_ren), .sys_rdata_i(sys_rdata), .sys_err_i(sys_err),
        .sys_ack_i(sys_ack | stray_ack)
    );

    axi_burst_slave #(.AXI_DW(DW), .AXI_AW(AW), .AXI_IW(IW), .AXI_LW(LW), .ARB_RR(0), .TIMEOUT(TO)) u_dut_wp (
        .axi_clk_i(clk), .axi_rst_i(rst),
        .axi_awid_i(awid), .axi_awaddr_i(awaddr), .axi_awlen_i(awlen), .axi_awsize_i(awsize),
        .axi_awburst_i(awburst), .axi_awvalid_i(awvalid), .axi_awready_o(awready_0),
        .axi_wdata_i(wdata), .axi_wstrb_i(wstrb), .axi_wlast_i(wlast), .axi_wvalid_i(wvalid),
        .axi_wready_o(wready_0),
        .axi_bid_o(bid_0), .axi_bresp_o(bresp_0), .axi_bvalid_o(bvalid_0), .axi_bready_i(bready),
        .axi_arid_i(arid), .axi_araddr_i(araddr), .axi_arlen_i(arlen), .axi_arsize_i(arsize),
        .axi_arburst_i(arburst), .axi_arvalid_i(arvalid), .axi_arready_o(arready_0),
        .axi_rid_o(rid_0), .axi_rdata_o(rdata_0), .axi_rresp_o(rresp_0), .axi_rlast_o(rlast_0),
        .axi_rvalid_o(rvalid_0), .axi_rready_i(rready),
        .sys_addr_o(s_addr_0), .sys_wdata_o(s_wdata_0), .sys_sel_o(s_sel_0), .sys_wen_o(s_wen_0),
        .sys_ren_o(s_ren_0), .sys_rdata_i(sys_rdata), .sys_err_i(sys_err),
        .sys_ack_i(sys_ack | stray_ack)
    );

    // System-bus responder: acks ack_dly cycles after each access (never when negative).
    int              ack_dly = 2;
    logic            resp_err = 0;
    int              n_wen = 0, n_ren = 0, n_acc = 0, wen_hi = 0;
    int              wen_cyc = 0, ren_cyc = 0, ack_cyc = 0, acnt = 0;
    bit              pend = 0;
    logic [AW-1:0]   alog [0:63];
    logic [DW/8-1:0] sel_log [0:63];
    logic [DW-1:0]   wd_log [0:63];

    always @(negedge clk) begin
        sys_ack   = 1'b0;
        sys_err   = 1'b0;
        sys_rdata = 32'hDEAD_BEEF;
        if (s_wen) wen_hi++;
        if (rst) begin
            pend = 0;
        end else if (pend) begin
            if (acnt == ack_dly) begin
                sys_ack   = 1'b1;
                sys_err   = resp_err;
                sys_rdata = 32'hD000_0000 | s_addr;
                ack_cyc   = cyc;
                pend      = 0;
            end else begin
                acnt++;
            end
        end else if (s_wen || s_ren) begin
            if (n_acc < 64) begin
                alog[n_acc]    = s_addr;
                sel_log[n_acc] = s_sel;
                wd_log[n_acc]  = s_wdata;
            end
            n_acc++;
            if (s_wen) begin n_wen++; wen_cyc = cyc; end
            else begin n_ren++; ren_cyc = cyc; end
            pend = (ack_dly > 0);
            acnt = 1;
        end
    end

    int n_chk = 0, n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic aw_send(input logic [IW-1:0] id, input logic [AW-1:0] a, input logic [LW-1:0] l,
                           input logic [2:0] sz, input logic [1:0] b);
        awid = id; awaddr = a; awlen = l; awsize = sz; awburst = b; awvalid = 1;
        #1 chk("awready", awready, 1);
        @(negedge clk); awvalid = 0;
    endtask

    task automatic ar_send(input logic [IW-1:0] id, input logic [AW-1:0] a, input logic [LW-1:0] l,
                           input logic [2:0] sz, input logic [1:0] b);
        arid = id; araddr = a; arlen = l; arsize = sz; arburst = b; arvalid = 1;
        #1 chk("arready", arready, 1);
        @(negedge clk); arvalid = 0;
    endtask

    task automatic w_beats(input int n, input int total);
        for (int i = 0; i < n; i++) begin
            int t = 0;
            while (!wready && t < 100) begin @(negedge clk); t++; end
            if (!wready) begin chk("wready_wait", wready, 1); return; end
            wdata = 32'h1000_0000 + i; wstrb = (DW/8)'(i + 1); wlast = (i == total - 1); wvalid = 1;
            @(negedge clk); wvalid = 0; wlast = 0;
        end
    endtask

    task automatic b_wait(input logic [1:0] exp_resp, input logic [IW-1:0] exp_id);
        int t = 0;
        while (!bvalid && t < 200) begin @(negedge clk); t++; end
        chk("bvalid", bvalid, 1);
        chk("bresp", bresp, exp_resp);
        chk("bid", bid, exp_id);
        bready = 1; @(negedge clk); bready = 0;
        chk("bvalid_drop", bvalid, 0);
    endtask

    task automatic r_wait();
        int t = 0;
        while (!rvalid && t < 200) begin @(negedge clk); t++; end
        chk("rvalid", rvalid, 1);
    endtask

    task automatic do_reset();
        rst = 1; @(negedge clk); @(negedge clk); rst = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int a0, w0, h0, r0, c0, rv_cyc, bv_seen;
        repeat (3) @(negedge clk);
        chk("rst_awready", awready, 0); chk("rst_arready", arready, 0);
        chk("rst_wready", wready, 0);   chk("rst_bvalid", bvalid, 0);
        chk("rst_rvalid", rvalid, 0);   chk("rst_wen", s_wen, 0);
        chk("rst_ren", s_ren, 0);       chk("rst_bresp", bresp, 0);
        chk("rst_rresp", rresp, 0);     chk("rst_rdata", rdata, 0);
        rst = 0;
        @(negedge clk);

        // INCR write: 4 beats at 0x100..0x10C, ack after 2 cycles
        a0 = n_acc; w0 = n_wen; h0 = wen_hi;
        aw_send(12'h005, 32'h100, 4'd3, 3'd2, 2'd1);
        w_beats(4, 4);
        b_wait(2'b00, 12'h005);
        chk("incr_wen_cnt", n_wen - w0, 4);
        chk("incr_wen_cycles", wen_hi - h0, 4);
        for (int i = 0; i < 4; i++) chk("incr_addr", alog[a0 + i], 32'h100 + 4 * i);
        chk("incr_sel2", sel_log[a0 + 2], 4'h3);
        chk("incr_wdata3", wd_log[a0 + 3], 32'h1000_0003);

        // sys_err on the only beat
        resp_err = 1;
        aw_send(12'h006, 32'h200, 4'd0, 3'd2, 2'd1);
        w_beats(1, 1);
        b_wait(2'b10, 12'h006);
        resp_err = 0;

        // narrow size: handshakes only, SLVERR, no sys write
        h0 = wen_hi;
        aw_send(12'h007, 32'h300, 4'd1, 3'd1, 2'd1);
        w_beats(2, 2);
        b_wait(2'b10, 12'h007);
        chk("size_err_no_wen", wen_hi - h0, 0);

        // FIXED read with a stalled master and a stray ack during the stall
        ack_dly = 1; a0 = n_acc; r0 = n_ren; c0 = cyc;
        ar_send(12'h021, 32'h40, 4'd1, 3'd2, 2'd0);
        r_wait();
        rv_cyc = cyc;
        chk("ren_latency", ren_cyc - c0, 1);
        chk("rvalid_latency", rv_cyc - ack_cyc, 1);
        chk("fixed_rdata0", rdata, 32'hD000_0040);
        chk("fixed_rresp0", rresp, 0);
        chk("fixed_rlast0", rlast, 0);
        chk("fixed_rid", rid, 12'h021);
        for (int i = 0; i < 5; i++) begin
            stray_ack = (i == 2);
            @(negedge clk); stray_ack = 0;
            chk("rdata_stall", {rvalid, rdata}, {1'b1, 32'hD000_0040});
        end
        rready = 1; @(negedge clk); rready = 0;
        r_wait();
        chk("fixed_rdata1", rdata, 32'hD000_0040);
        chk("fixed_rlast1", rlast, 1);
        rready = 1; @(negedge clk); rready = 0;
        chk("fixed_ren_cnt", n_ren - r0, 2);
        chk("fixed_addr0", alog[a0], 32'h40);
        chk("fixed_addr1", alog[a0 + 1], 32'h40);
        chk("fixed_idle", rvalid, 0);

        // WRAP read: error burst, no sys reads
        r0 = n_ren; rready = 1;
        ar_send(12'h022, 32'h80, 4'd3, 3'd2, 2'd2);
        for (int i = 0; i < 4; i++) begin
            r_wait();
            chk("wrap_rresp", rresp, 2'b10);
            chk("wrap_rlast", rlast, (i == 3));
            @(negedge clk);
        end
        rready = 0;
        chk("wrap_no_ren", n_ren - r0, 0);
        chk("wrap_idle", rvalid, 0);
        ack_dly = 2;

        // Arbitration: two contests after reset
        do_reset();
        awid = 12'h008; awaddr = 32'h400; awlen = 0; awsize = 2; awburst = 1;
        arid = 12'h009; araddr = 32'h480; arlen = 0; arsize = 2; arburst = 1;
        awvalid = 1; arvalid = 1;
        #1;
        chk("arb1_rr_aw", awready, 1);   chk("arb1_rr_ar", arready, 0);
        chk("arb1_wp_aw", awready_0, 1); chk("arb1_wp_ar", arready_0, 0);
        @(negedge clk); awvalid = 0; arvalid = 0;
        w_beats(1, 1);
        b_wait(2'b00, 12'h008);
        awvalid = 1; arvalid = 1;
        #1;
        chk("arb2_rr_aw", awready, 0);   chk("arb2_rr_ar", arready, 1);
        chk("arb2_wp_aw", awready_0, 1); chk("arb2_wp_ar", arready_0, 0);
        @(negedge clk); awvalid = 0; arvalid = 0;
        do_reset();

        // Never-acked single write
        ack_dly = -1;
        aw_send(12'h00A, 32'h500, 4'd0, 3'd2, 2'd1);
        w_beats(1, 1);
`ifdef AXI_BURST_SLAVE_TIMEOUT_EN
        begin
            int t = 0;
            while (!bvalid && t < 100) begin @(negedge clk); t++; end
            chk("to_bvalid", bvalid, 1);
            chk("to_latency", cyc - wen_cyc, TO);
            chk("to_bresp", bresp, 2'b10);
            bready = 1; @(negedge clk); bready = 0;
        end
`else
        bv_seen = 0;
        repeat (TO * 4) begin
            @(negedge clk);
            if (bvalid) bv_seen++;
        end
        chk("no_to_bvalid", bv_seen, 0);
        do_reset();
`endif
        ack_dly = 2;

        // Reset during beat 2 of 4, then a fresh write
        aw_send(12'h00B, 32'h600, 4'd3, 3'd2, 2'd1);
        w_beats(2, 4);
        rst = 1;
        @(negedge clk);
        chk("mid_wen", s_wen, 0);       chk("mid_wready", wready, 0);
        chk("mid_bvalid", bvalid, 0);   chk("mid_rvalid", rvalid, 0);
        chk("mid_awready", awready, 0); chk("mid_ren", s_ren, 0);
        chk("mid_bresp", bresp, 0);
        rst = 0;
        @(negedge clk);
        a0 = n_acc;
        aw_send(12'h00C, 32'h700, 4'd0, 3'd2, 2'd1);
        w_beats(1, 1);
        b_wait(2'b00, 12'h00C);
        chk("post_rst_addr", alog[a0], 32'h700);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
